// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : MEM-stage load/store unit. Drives a req/gnt + rvalid data bus,
//                stalls the pipeline until the access completes, and holds the
//                MEM/WB pipeline register. Optional: MEM_MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_alu_result_MEM,
    input  logic [XLEN-1:0] i_dataB_MEM,
    input  logic [XLEN-1:0] i_pc_plus4_MEM,
    input  logic [RD_W-1:0] i_addr_des_MEM,
    input  logic            i_reg_write_MEM,
    input  logic            i_mem_write_MEM,
    input  logic [1:0]      i_result_src_MEM,
    output logic            o_stall_MEM,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            o_misalign_MEM,
`endif
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_alu_result_WB,
    output logic [XLEN-1:0] o_read_data_WB,
    output logic [XLEN-1:0] o_pc_plus4_WB,
    output logic [RD_W-1:0] o_addr_des_WB,
    output logic            o_reg_write_WB,
    output logic [1:0]      o_result_src_WB
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;

    logic mem_op;
    logic misalign;
    logic issue;
    logic req;
    logic stall;
    logic resp;

    assign mem_op = i_mem_write_MEM | (i_result_src_MEM == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
    // A misaligned access never reaches the bus; it retires as a bubble.
    assign misalign       = i_rst_n & mem_op & (state == IDLE) & (i_alu_result_MEM[1:0] != 2'b00);
    assign o_misalign_MEM = misalign;
`else
    assign misalign = 1'b0;
`endif

    assign issue = mem_op & ~misalign;
    // The reset term keeps req/stall low while the FSM is held in IDLE.
    assign req   = i_rst_n & (((state == IDLE) & issue) | (state == REQ));
    assign resp  = (state == WAIT) & i_dmem_rvalid;
    assign stall = req | ((state == WAIT) & ~i_dmem_rvalid);

    assign o_stall_MEM  = stall;
    assign o_dmem_req   = req;
    assign o_dmem_we    = req & i_mem_write_MEM;
    assign o_dmem_wdata = req ? i_dataB_MEM : '0;
`ifdef MEM_MISALIGN_TRAP_EN
    assign o_dmem_addr  = req ? i_alu_result_MEM : '0;
`else
    assign o_dmem_addr  = req ? {i_alu_result_MEM[XLEN-1:2], 2'b00} : '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (issue) state <= i_dmem_gnt ? WAIT : REQ;
                REQ:     if (i_dmem_gnt) state <= WAIT;
                WAIT:    if (i_dmem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_alu_result_WB <= '0;
            o_read_data_WB  <= '0;
            o_pc_plus4_WB   <= '0;
            o_addr_des_WB   <= '0;
            o_reg_write_WB  <= 1'b0;
            o_result_src_WB <= 2'b00;
        end else if (!stall) begin
            o_alu_result_WB <= i_alu_result_MEM;
            o_read_data_WB  <= resp ? i_dmem_rdata : '0;
            o_pc_plus4_WB   <= i_pc_plus4_MEM;
            o_addr_des_WB   <= i_addr_des_MEM;
            o_reg_write_WB  <= i_reg_write_MEM & ~misalign;
            o_result_src_WB <= i_result_src_MEM;
        end else begin
            o_reg_write_WB  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
